// File: rtl/booth_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
//   - Booth digit codes (3-bit signed-magnitude-ish tags used by the pp selector)
//   - FSM state type
//   - booth_enc(): maps a {b1,b0,lookback} window to a digit code
package booth_pkg;

   localparam logic [2:0] ZERO = 3'b000;
   localparam logic [2:0] P1   = 3'b001;
   localparam logic [2:0] P2   = 3'b010;
   localparam logic [2:0] N1   = 3'b111;
   localparam logic [2:0] N2   = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [2:0] booth_enc(input logic [2:0] win);
      logic [2:0] dig;
      case (win)
         3'b001, 3'b010: dig = P1;
         3'b011:         dig = P2;
         3'b100:         dig = N2;
         3'b101, 3'b110: dig = N1;
         default:        dig = ZERO;
      endcase
      return dig;
   endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product selector.
//   win  in   3   {b1,b0,lookback} window of the multiplier register
//   a    in   W   extended multiplicand
//   pp   out  W   selected partial product (one's complement for negative digits)
//   neg  out  1   carry-in completing the two's complement of a negative digit
module booth_r4_pp
   import booth_pkg::*;
#(
   parameter int W = 12
)
(
   input  logic [2:0]   win,
   input  logic [W-1:0] a,
   output logic [W-1:0] pp,
   output logic         neg
);

   logic [2:0]   dig;
   logic [W-1:0] a2;

   assign a2 = {a[W-2:0], 1'b0};

   always_comb begin
      dig = booth_enc(win);
      pp  = '0;
      neg = 1'b0;
      case (dig)
         P1: pp = a;
         P2: pp = a2;
         N1: begin
            pp  = ~a;
            neg = 1'b1;
         end
         N2: begin
            pp  = ~a2;
            neg = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/booth_r4_iter_mul.sv
// Iterative radix-4 Booth multiplier: one digit per clock, shift-add accumulator.
// Optional feature macro: BOOTH_R4_EARLY_TERM_EN (stop once the remaining digits are all zero).
//   clk, rst_n            clock / async active-low reset
//   in_valid/in_ready     operand handshake; in_a multiplicand, in_b multiplier, in_signed mode
//   out_valid/out_ready   product handshake; out_p product, out_ndig digits iterated
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | retiring one Booth digit per cycle; one extra cycle after the last digit
// DONE  | product presented, held until out_ready
module booth_r4_iter_mul
   import booth_pkg::*;
#(
   parameter int DWIDTH = 24
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DWIDTH-1:0]      in_a,
   input  logic [DWIDTH-1:0]      in_b,
   input  logic                   in_signed,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*DWIDTH-1:0]    out_p,
   output logic [$clog2(((2*((DWIDTH+2)/2))/2)+1)-1:0] out_ndig
);

   localparam int EW   = 2*((DWIDTH+2)/2);
   localparam int NDIG = EW/2;
   localparam int CW   = $clog2(NDIG+1);
   localparam int AW   = 2*EW+2;

   state_t        state;
   logic [EW+1:0] a_ext;
   logic [EW:0]   mreg;
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic          fin;

   logic [EW+1:0] pp;
   logic          neg;
   logic [EW+1:0] hi_sum;
   logic [AW-1:0] acc_sum;
   logic [AW-1:0] acc_sh;
   logic [AW-1:0] acc_nxt;
   logic [EW:0]   mreg_sh;
   logic [CW-1:0] cnt_inc;
   logic          fin_nxt;
   logic          ext_a;
   logic          ext_b;

   booth_r4_pp #(.W(EW+2)) u_pp (
      .win (mreg[2:0]),
      .a   (a_ext),
      .pp  (pp),
      .neg (neg)
   );

   assign ext_a = in_signed & in_a[DWIDTH-1];
   assign ext_b = in_signed & in_b[DWIDTH-1];

   // Partial product enters at the top of the accumulator; the whole
   // accumulator then shifts right so that after NDIG digits it holds a*b.
   always_comb begin
      hi_sum  = acc[AW-1:EW] + pp + {{(EW+1){1'b0}}, neg};
      acc_sum = {hi_sum, acc[EW-1:0]};
      acc_sh  = $signed(acc_sum) >>> 2;
      mreg_sh = $signed(mreg) >>> 2;
      cnt_inc = cnt + CW'(1);
      fin_nxt = (cnt_inc == CW'(NDIG));
      acc_nxt = acc_sh;
`ifdef BOOTH_R4_EARLY_TERM_EN
      // Uniform remaining bits mean every remaining digit encodes to zero;
      // fold the outstanding shifts in now so the product stays exact.
      if ((&mreg_sh) || (~|mreg_sh)) begin
         fin_nxt = 1'b1;
         acc_nxt = $signed(acc_sh) >>> (2*(NDIG - int'(cnt_inc)));
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_ext    <= '0;
         mreg     <= '0;
         acc      <= '0;
         cnt      <= '0;
         fin      <= 1'b0;
         out_p    <= '0;
         out_ndig <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_ext <= {{(EW+2-DWIDTH){ext_a}}, in_a};
                  mreg  <= {{(EW-DWIDTH){ext_b}}, in_b, 1'b0};
                  acc   <= '0;
                  cnt   <= '0;
                  fin   <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (fin) begin
                  out_p    <= acc[2*DWIDTH-1:0];
                  out_ndig <= cnt;
                  state    <= DONE;
               end else begin
                  acc  <= acc_nxt;
                  mreg <= mreg_sh;
                  cnt  <= cnt_inc;
                  fin  <= fin_nxt;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_booth_r4_iter_mul.sv
module tb_booth_r4_iter_mul;

`ifdef BOOTH_R4_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam int DW = 8;
   localparam int NDIG = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_signed = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_p;
   logic [2:0]  out_ndig;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   booth_r4_iter_mul #(.DWIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_ndig  (out_ndig)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // en_early: digits expected with early termination (-1: do not check ndig/latency then)
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                         input logic [15:0] ep, input int en_early, input int stall);
      int lat;
      int exp_nd;
      bit chk_nd;
      exp_nd = EARLY ? en_early : NDIG;
      chk_nd = !(EARLY && en_early < 0);
      @(negedge clk);
      in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1;
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = ~a; in_b = ~b; in_signed = ~sgn;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("out_valid_seen", 32'(out_valid), 32'd1);
      if (chk_nd) begin
         chk("latency", 32'(lat), 32'(exp_nd + 1));
         chk("ndig", 32'(out_ndig), 32'(exp_nd));
      end
      chk("product", 32'(out_p), 32'(ep));
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_p", 32'(out_p), 32'(ep));
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_p_held", 32'(out_p), 32'(ep));
   endtask

   initial begin
      logic [7:0]  ra, rb;
      logic        rs;
      logic [15:0] rp;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_p", 32'(out_p), 32'd0);
      chk("rst_ndig", 32'(out_ndig), 32'd0);
      rst_n = 1'b1;

      run_op(8'h80, 8'h80, 1'b1, 16'h4000, 4, 3);
      run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 5, 0);
      run_op(8'h80, 8'h7F, 1'b1, 16'hC080, 4, 0);
      run_op(8'hFF, 8'h01, 1'b1, 16'hFFFF, 1, 0);
      run_op(8'h03, 8'h01, 1'b0, 16'h0003, 1, 0);
      run_op(8'h05, 8'hFF, 1'b1, 16'hFFFB, 1, 1);
      run_op(8'h81, 8'h81, 1'b1, 16'h3F01, 4, 0);
      run_op(8'h7F, 8'h80, 1'b1, 16'hC080, 4, 0);
      run_op(8'h80, 8'h02, 1'b0, 16'h0100, 2, 0);
      run_op(8'hAB, 8'h00, 1'b0, 16'h0000, 1, 0);
      run_op(8'h00, 8'hAB, 1'b0, 16'h0000, 5, 0);

      // reset in the middle of RUN
      @(negedge clk);
      in_a = 8'h55; in_b = 8'h66; in_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_p", 32'(out_p), 32'd0);
      chk("abort_ndig", 32'(out_ndig), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h03, 8'h05, 1'b0, 16'h000F, 2, 0);

      // scoreboard sweep; ndig/latency only checked where fixed
      for (int k = 0; k < 200; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         if (rs) rp = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
         else    rp = 16'({8'h00, ra} * {8'h00, rb});
         run_op(ra, rb, rs, rp, -1, int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
